// File: rtl/drive_state_ctrl_if.sv
// drive_state_ctrl_if: raw switch inputs and car state outputs of drive_state_ctrl
interface drive_state_ctrl_if;
    logic       power_btn;
    logic       throttle;
    logic       brake;
    logic       clutch;
    logic       reverse_sw;
    logic       left_sw;
    logic       right_sw;
    logic [3:0] state;
    logic       power_now;
    logic [3:0] answer;
    modport master (
        output power_btn, throttle, brake, clutch, reverse_sw, left_sw, right_sw,
        input  state, power_now, answer
    );
    modport slave (
        input  power_btn, throttle, brake, clutch, reverse_sw, left_sw, right_sw,
        output state, power_now, answer
    );
endinterface

// File: rtl/drive_state_ctrl.sv
// drive_state_ctrl: input sync, power-button debounce/hold toggle and car drive FSM; STALL_PROTECT_EN enables stall shutdown
module drive_state_ctrl #(
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int PWR_HOLD_CYC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    drive_state_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(PWR_HOLD_CYC + 1);
    typedef enum logic [3:0] {
        ST_UNSTART = 4'b0001,
        ST_START   = 4'b0010,
        ST_MOVE    = 4'b0100,
        ST_OFF     = 4'b1000
    } state_t;
    logic [6:0]    r_s1;
    logic [6:0]    r_s2;
    logic          r_stable;
    logic [DW-1:0] r_dcnt;
    logic          r_armed;
    logic [HW-1:0] r_hcnt;
    logic          r_toggle;
    state_t        r_state;
    logic          r_power_now;
    logic [3:0]    r_answer;
    state_t        w_next;
    logic [3:0]    w_answer;
    logic          w_pwr, w_thr, w_brk, w_clu, w_rev, w_lft, w_rgt;
    logic          w_stall_un;
    logic          w_stall_mv;
    logic          w_go;
    logic          w_mv;

    assign {w_pwr, w_thr, w_brk, w_clu, w_rev, w_lft, w_rgt} = r_s2;
    assign bus.state     = r_state;
    assign bus.power_now = r_power_now;
    assign bus.answer    = r_answer;

`ifdef STALL_PROTECT_EN
    logic r_rev_d;
    // remember last synchronised gear position to detect a shift
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_rev_d <= 1'b0;
        else      r_rev_d <= w_rev;
    assign w_stall_un = w_thr & ~w_clu;
    assign w_stall_mv = (w_rev ^ r_rev_d) & ~w_clu;
`else
    assign w_stall_un = 1'b0;
    assign w_stall_mv = 1'b0;
`endif

    // two-flop synchroniser for every raw input
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {bus.power_btn, bus.throttle, bus.brake, bus.clutch, bus.reverse_sw, bus.left_sw, bus.right_sw};
            r_s2 <= r_s1;
        end

    // debounce; stable value resets high so a button held through reset must be released before it can arm
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_stable <= 1'b1;
            r_dcnt   <= '0;
        end else if (w_pwr == r_stable) begin
            r_dcnt   <= '0;
        end else if (r_dcnt == DW'(DEBOUNCE_CYC - 1)) begin
            r_stable <= w_pwr;
            r_dcnt   <= '0;
        end else begin
            r_dcnt   <= r_dcnt + DW'(1);
        end

    // long-press detector: one registered toggle pulse per armed press
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_armed  <= 1'b0;
            r_hcnt   <= '0;
            r_toggle <= 1'b0;
        end else begin
            r_toggle <= 1'b0;
            if (!r_stable) begin
                r_armed <= 1'b1;
                r_hcnt  <= '0;
            end else if (r_armed) begin
                if (r_hcnt == HW'(PWR_HOLD_CYC - 1)) begin
                    r_toggle <= 1'b1;
                    r_armed  <= 1'b0;
                    r_hcnt   <= '0;
                end else begin
                    r_hcnt <= r_hcnt + HW'(1);
                end
            end
        end

    // next state in priority order, and answer derived from that same next state
    always_comb begin
        w_next = r_state;
        if (r_toggle)
            w_next = (r_state == ST_OFF) ? ST_UNSTART : ST_OFF;
        else if (r_state != ST_OFF) begin
            if (w_brk && r_state != ST_UNSTART)
                w_next = ST_UNSTART;
            else if (r_state == ST_UNSTART)
                w_next = (w_clu && w_thr && !w_brk) ? ST_START : w_stall_un ? ST_OFF : ST_UNSTART;
            else if (r_state == ST_START)
                w_next = (w_thr && !w_clu && !w_brk) ? ST_MOVE : ST_START;
            else
                w_next = (w_clu || !w_thr) ? ST_START : w_stall_mv ? ST_OFF : ST_MOVE;
        end
        w_mv = (w_next == ST_MOVE);
        w_go = w_mv || (w_next == ST_START);
        w_answer = {w_go & w_lft & ~w_rgt, w_go & w_rgt & ~w_lft, w_mv & w_rev, w_mv & ~w_rev};
    end

    // registered state and outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state     <= ST_OFF;
            r_power_now <= 1'b1;
            r_answer    <= 4'b0000;
        end else begin
            r_state     <= w_next;
            r_power_now <= (w_next == ST_OFF);
            r_answer    <= w_answer;
        end
endmodule

// File: tb/tb_drive_state_ctrl.sv
// tb_drive_state_ctrl: scoreboard bench for drive_state_ctrl against a behavioural car model
module tb_drive_state_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int UN = 0, ST = 1, MV = 2, OFF = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    drive_state_ctrl_if bus();
    drive_state_ctrl #(.DEBOUNCE_CYC(DEB), .PWR_HOLD_CYC(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    // model state: car mode, pending toggle, debounce and hold progress, input delay line
    int       m_state = OFF;
    bit       m_tog, m_stable = 1'b1, m_armed, m_prev_rev;
    int       m_run, m_held;
    bit [6:0] m_hist[$] = '{7'd0, 7'd0};

    function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // reference model: advance one clock and push the expected outputs
    always @(posedge clk) begin : model
        bit [6:0] y;
        bit [6:0] raw;
        bit       go, mv;
        logic [3:0] ans;
        raw = {bus.power_btn, bus.throttle, bus.brake, bus.clutch, bus.reverse_sw, bus.left_sw, bus.right_sw};
        ans = 4'b0000;
        if (!rst) begin
            m_state = OFF; m_tog = 0; m_stable = 1; m_armed = 0; m_prev_rev = 0;
            m_run = 0; m_held = 0; m_hist = '{7'd0, 7'd0};
        end else begin
            y = m_hist.pop_front();
            m_hist.push_back(raw);
            if (m_tog) m_state = (m_state == OFF) ? UN : OFF;
            else if (m_state != OFF) begin
                if (y[4] && m_state != UN) m_state = UN;
                else if (m_state == UN) begin
                    if (y[3] && y[5] && !y[4]) m_state = ST;
`ifdef STALL_PROTECT_EN
                    else if (y[5] && !y[3]) m_state = OFF;
`endif
                end else if (m_state == ST) begin
                    if (y[5] && !y[3] && !y[4]) m_state = MV;
                end else begin
                    if (y[3] || !y[5]) m_state = ST;
`ifdef STALL_PROTECT_EN
                    else if (y[2] != m_prev_rev) m_state = OFF;
`endif
                end
            end
            m_tog = 0;
            if (!m_stable) begin m_armed = 1; m_held = 0; end
            else if (m_armed) begin
                m_held++;
                if (m_held == HOLD) begin m_tog = 1; m_armed = 0; m_held = 0; end
            end
            if (y[6] == m_stable) m_run = 0;
            else begin
                m_run++;
                if (m_run == DEB) begin m_stable = y[6]; m_run = 0; end
            end
            m_prev_rev = y[2];
            go = (m_state == ST) || (m_state == MV);
            mv = (m_state == MV);
            ans = {go && y[1] && !y[0], go && y[0] && !y[1], mv && y[2], mv && !y[2]};
        end
        exp_q.push_back({4'(1 << m_state), m_state == OFF, ans});
    end

    // monitor: pop one expected entry per output cycle and compare
    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("state", bus.state, e[8:5]);
                check("power_now", {3'b000, bus.power_now}, {3'b000, e[4]});
                check("answer", bus.answer, e[3:0]);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.power_btn = 0; bus.throttle = 0; bus.brake = 0; bus.clutch = 0;
        bus.reverse_sw = 0; bus.left_sw = 0; bus.right_sw = 0;
    endtask

    task automatic power_press();
        bus.power_btn = 1;
        cyc(30);
        bus.power_btn = 0;
        cyc(10);
    endtask

    initial begin : stim
        idle();
        cyc(5);
        check("rst_state", bus.state, 4'b1000);
        check("rst_power_now", {3'b000, bus.power_now}, 4'b0001);
        check("rst_answer", bus.answer, 4'b0000);
        rst = 1;
        cyc(10);
        check("post_rst_state", bus.state, 4'b1000);
        bus.power_btn = 1;
        cyc(22);
        check("pre_toggle_state", bus.state, 4'b1000);
        cyc(1);
        check("toggle_at_23", bus.state, 4'b0001);
        cyc(17);
        check("held_no_retoggle", bus.state, 4'b0001);
        bus.power_btn = 0;
        cyc(10);
        bus.power_btn = 1;
        cyc(3);
        bus.power_btn = 0;
        cyc(30);
        check("bounce_ignored", bus.state, 4'b0001);
        bus.clutch = 1; bus.throttle = 1;
        cyc(5);
        check("drive_starting", bus.state, 4'b0010);
        bus.clutch = 0;
        cyc(5);
        check("drive_moving", bus.state, 4'b0100);
        check("drive_fwd", bus.answer, 4'b0001);
        bus.reverse_sw = 1; bus.clutch = 1;
        cyc(5);
        check("rev_clutch_state", bus.state, 4'b0010);
        check("rev_clutch_answer", bus.answer, 4'b0000);
        bus.reverse_sw = 0;
        cyc(5);
        bus.clutch = 0;
        cyc(5);
        bus.left_sw = 1;
        cyc(5);
        check("turn_left", bus.answer, 4'b1001);
        bus.right_sw = 1;
        cyc(5);
        check("turn_both", bus.answer, 4'b0001);
        bus.brake = 1;
        cyc(5);
        check("brake_state", bus.state, 4'b0001);
        check("brake_answer", bus.answer, 4'b0000);
        idle();
        cyc(5);
        bus.throttle = 1;
        cyc(5);
`ifdef STALL_PROTECT_EN
        check("stall_state", bus.state, 4'b1000);
        check("stall_power_now", {3'b000, bus.power_now}, 4'b0001);
        bus.throttle = 0;
        cyc(5);
        power_press();
`else
        check("stall_ignored", bus.state, 4'b0001);
        bus.throttle = 0;
        cyc(5);
`endif
        power_press();
        check("power_off", bus.state, 4'b1000);
        power_press();
        check("power_on_again", bus.state, 4'b0001);
        bus.power_btn = 1;
        cyc(10);
        rst = 0;
        cyc(2);
        rst = 1;
        cyc(40);
        check("midhold_rst_no_toggle", bus.state, 4'b1000);
        bus.power_btn = 0;
        cyc(10);
        check("midhold_released", bus.state, 4'b1000);
        power_press();
        check("midhold_new_hold", bus.state, 4'b0001);
        for (int k = 0; k < 400; k++) begin
            bus.throttle   = ($urandom_range(0, 3) != 0);
            bus.clutch     = ($urandom_range(0, 2) == 0);
            bus.brake      = ($urandom_range(0, 6) == 0);
            bus.reverse_sw = ($urandom_range(0, 3) == 0) ? ~bus.reverse_sw : bus.reverse_sw;
            bus.left_sw    = $urandom_range(0, 1);
            bus.right_sw   = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) bus.power_btn = ~bus.power_btn;
            if ($urandom_range(0, 60) == 0) begin
                rst = 0;
                cyc($urandom_range(1, 3));
                rst = 1;
            end
            cyc($urandom_range(1, 25));
        end
        idle();
        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/drive_state_ctrl.md
# drive_state_ctrl

Upstream control stage for the car: it synchronises the raw switch and button inputs, debounces the power button, and runs the car's power and drive state machine. It produces the one-hot car `state`, the `power_now` flag and the 4-bit `answer` direction vector. The turn-signal lamp logic, the odometer and the motor drivers consume these outputs directly.

## Interface
- `DEBOUNCE_CYC`, default 2_000_000: consecutive stable cycles required before the debounced power button changes (20 ms at 100 MHz).
- `PWR_HOLD_CYC`, default 100_000_000: cycles the debounced power button must be held to toggle power (1 s).
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `power_btn` in 1: raw power push-button, active-high.
- `throttle`, `brake`, `clutch` in 1 each: raw pedal switches, active-high.
- `reverse_sw` in 1: raw gear switch; 1 selects reverse.
- `left_sw`, `right_sw` in 1 each: raw turn switches.
- `state` out 4: one-hot car state.
  - 4'b0001: unstarting.
  - 4'b0010: starting.
  - 4'b0100: moving.
  - 4'b1000: power_off.
- `power_now` out 1: 1 exactly while `state`==power_off. Downstream lamp blocks hold idle while it is high.
- `answer` out 4: `[3]` left, `[2]` right, `[1]` back, `[0]` forward.

## Operation
- **Input path:** every raw input passes through a 2-flop synchroniser.
  - `power_btn` is then debounced. A counter clears whenever the synchronised value equals the stable value. Otherwise it increments, and the stable value flips when the count reaches `DEBOUNCE_CYC-1`.
- **Power hold:**
  - An `armed` flag sets when the debounced button is 0.
  - While the button is 1 and `armed` is set, the hold counter increments.
  - When the count reaches `PWR_HOLD_CYC-1`, power toggles, `armed` clears and the counter clears.
  - Button release clears the counter.
  - One long press gives exactly one toggle, regardless of how long it is held.
- **State machine.** Evaluate in order; the first match wins.
  - Power toggle in any powered state -> power_off.
  - power_off: power toggle -> unstarting.
  - brake=1 in starting or moving -> unstarting.
  - unstarting: clutch & throttle & !brake -> starting. Stall (throttle & !clutch) -> see Configuration.
  - starting: throttle & !clutch & !brake -> moving.
  - moving:
    - clutch | !throttle -> starting.
    - A change of `reverse_sw` while !clutch -> see Configuration.
  - Otherwise the state holds.
- **answer:**
  - `[0]` = (state==moving) & !reverse.
  - `[1]` = (state==moving) & reverse.
  - `[3]` = (starting|moving) & left & !right.
  - `[2]` = (starting|moving) & right & !left.
  - With both turn switches on, neither turn bit is set.
  - In unstarting and power_off, `answer` = 0.
- All outputs are registered. `power_now` and `answer` derive from the same next-state value, so they are never inconsistent with `state` in any cycle.

## Timing
- **Reset** (`rst`=0, asynchronous): `state`=4'b1000, `power_now`=1, `answer`=4'b0000. All counters clear and `armed` clears.
  - Reset asserted mid-hold or mid-debounce discards the progress.
  - After reset release, the button must be seen released before a hold counts.
- **Pedal/switch latency:** a raw edge reaches `state`/`answer` 3 cycles later (2 synchroniser cycles + 1 output register).
- **Power toggle latency:** 2 + `DEBOUNCE_CYC` + `PWR_HOLD_CYC` + 1 cycles from a clean press to the `state` change.
- **Simultaneous events:**
  - Power toggle and brake in the same cycle: power_off wins.
  - Brake with clutch+throttle in unstarting: state holds.
  - Reverse change together with clutch=1 in moving: moving -> starting, no shutdown.
- **Glitches:** power button bounces shorter than `DEBOUNCE_CYC` never reach the hold counter.

## Configuration
- `STALL_PROTECT_EN` defined:
  - unstarting with throttle & !clutch -> power_off.
  - moving with a `reverse_sw` change while !clutch -> power_off.
- `STALL_PROTECT_EN` undefined:
  - Both conditions are ignored: unstarting holds and moving holds.
  - `answer[1:0]` follows `reverse_sw` immediately.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `PWR_HOLD_CYC`=16.
- **Reset:** `rst`=0 for 5 cycles -> `state`=1000, `power_now`=1, `answer`=0; values hold after release.
- **Power on/off:**
  - `power_btn`=1 for 40 cycles -> `state`=0001 exactly once, at cycle 2+4+16+1=23, and no second toggle while still held.
  - Release, then hold again for 40 cycles -> `state`=1000.
  - A 3-cycle bounce pulse -> no change.
- **Drive path:** from unstarting, clutch=1, throttle=1 -> 0010. Then clutch=0 -> 0100, `answer`=0001. Then reverse_sw=1 with clutch=1 -> 0010, and `answer[1:0]`=00 while in starting.
- **Turn bits:** in moving, left_sw=1 -> `answer`=1001. Set right_sw=1 as well -> `answer`=0001. Then brake=1 -> 0001 state, `answer`=0000.
- **Stall:**
  - With `STALL_PROTECT_EN` defined: unstarting, throttle=1, clutch=0 -> 1000, `power_now`=1.
  - With it undefined: state stays 0001.
- **Reset mid-hold:** hold `power_btn` for 10 cycles, pulse `rst` low -> hold progress discarded; a toggle requires release and then a full new hold.
